pattern_capture: RTL and testbench
==================================

PATTERN_CAPTURE -- requirements
Module: pattern_capture

Interface
REQ-001 SHALL have parameter _PAT_WIDTH, default 8, meaning maximum captured pattern bits (2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cap_en  input  1  capture enable, level.
REQ-005 SHALL have port din  input  1  asynchronous pattern line (pwm_out of the pattern generator).
REQ-006 SHALL have port duty_num  input  8  bit period minus one, i.e. bit period = duty_num+1 cycles.
REQ-007 SHALL have port gap_min  input  16  consecutive low cycles that close a burst.
REQ-008 SHALL have port pat_out  output  _PAT_WIDTH  recovered pattern, bit0 = first high bit of the burst.
REQ-009 SHALL have port pat_len  output  8  index of highest set bit in pat_out, plus 1.
REQ-010 SHALL have port pat_valid  output  1  one-cycle strobe qualifying pat_out/pat_len.
REQ-011 SHALL have port pulse_cnt  output  8  completed bursts since cap_en rose, saturating at 255.
REQ-012 SHALL have port busy  output  1  high in SAMPLE and DONE.
REQ-013 SHALL have port overflow  output  1  sticky; burst exceeded _PAT_WIDTH bits.

Function
REQ-014 din SHALL pass a 2-FF synchronizer; all references below are to synchronized din (ds), with rising edge = ds high and previous ds low.
REQ-015 FSM states SHALL be IDLE, HUNT, SAMPLE, DONE.
REQ-016 IDLE -> HUNT when cap_en=1; on that transition pulse_cnt and overflow clear.
REQ-017 HUNT -> SAMPLE on ds rising edge; bit index := 0, phase counter := 0, low-run counter := 0, shift register := 0.
REQ-018 In SAMPLE, phase counter SHALL count 0..duty_num and wrap; ds SHALL be sampled when phase = duty_num>>1 (integer shift) and written to bit[index], then index increments.
REQ-019 Low-run counter SHALL increment each SAMPLE cycle with ds=0, clear on ds=1, and saturate at 16'hFFFF.
REQ-020 When low-run counter reaches gap_min: SAMPLE -> DONE.
REQ-021 If a sample at index >= _PAT_WIDTH reads 1, overflow SHALL set and the bit SHALL be discarded; zero samples beyond width are ignored.
REQ-022 DONE (one cycle): pat_out := shift register, pat_len := highest set index + 1, pat_valid=1, pulse_cnt += 1 unless 255; next state HUNT.
REQ-023 pat_out/pat_len SHALL hold until the next DONE.
REQ-024 Leading zero bits before the first high bit are not recoverable; pat_out bit0 is always 1 when pat_valid=1.
REQ-025 gap_min not exceeding the longest internal zero run of the pattern SHALL close the burst early; this is defined behaviour, not an error.
REQ-026 gap_min=0 SHALL be treated as 1.
REQ-027 cap_en=0 in any state SHALL force IDLE next cycle with no pat_valid; pulse_cnt and overflow hold.
REQ-028 Simultaneous DONE and cap_en=0: the DONE actions complete, then the FSM enters IDLE.
REQ-029 Latency: pat_valid SHALL assert exactly one cycle after the cycle in which the low-run counter equals gap_min.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, pat_out=0, pat_len=0, pat_valid=0, pulse_cnt=0, busy=0, overflow=0, synchronizer flops=0, and all counters=0.
REQ-031 Reset mid-burst SHALL discard the partial capture; the first burst after release requires a fresh rising edge.

Structure
REQ-032 The FSM state encodings (2-bit localparams) and the default width constants SHALL live in a shared package/include pattern_pkg, shared with the generator.
REQ-033 The synchronizer and edge detect SHALL be the sub-module pattern_sync2 (ports clk, rst, d, q, rise).
REQ-034 The remainder SHALL be single-module RTL of 120-400 lines.

Verification
REQ-035 The bench SHALL drive duty_num=3, gap_min=8, din = the 4-cycle-per-bit serialization of PAT=8'h0B followed by 20 low cycles -> one pat_valid, pat_out=8'h0B, pat_len=4, pulse_cnt=1.
REQ-036 The bench SHALL drive three bursts of PAT=8'h05 separated by gaps of 16 cycles -> three pat_valid, each pat_out=8'h05, pulse_cnt=3.
REQ-037 The bench SHALL drive _PAT_WIDTH=8 with a 10-bit all-ones burst -> overflow=1, pat_out=8'hFF, pat_len=8.
REQ-038 The bench SHALL drop cap_en mid-burst -> IDLE next cycle, no pat_valid, busy=0, pulse_cnt unchanged.
REQ-039 The bench SHALL assert rst mid-SAMPLE -> all outputs 0 immediately; a following PAT=8'h03 burst captures as 8'h03.
REQ-040 The bench SHALL drive duty_num=0, gap_min=0, and a single 1-cycle high pulse -> pat_out=1, pat_len=1, with pat_valid exactly 1 cycle after the first low sample.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern generator / capture pair: FSM encodings,
// default widths and a small bit-length helper.
package pattern_pkg;

  localparam int PAT_WIDTH_DEFAULT = 8;
  localparam int DUTY_WIDTH        = 8;
  localparam int GAP_WIDTH         = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HUNT   = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef struct packed {
    logic [7:0]           idx;
    logic [DUTY_WIDTH-1:0] phase;
    logic [GAP_WIDTH-1:0]  low_run;
  } sample_ctx_t;

  // Index of the highest set bit plus one; zero for an all-zero vector.
  function automatic logic [7:0] msb_len(input logic [63:0] v);
    logic [7:0] len;
    len = 8'd0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) len = 8'(i + 1);
    end
    return len;
  endfunction

endpackage

// File: rtl/pattern_sync2.sv
// Two-flop synchronizer for the asynchronous pattern line, with a rising-edge
// flag derived from the synchronized value and its previous cycle.
module pattern_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign q    = sync_reg;
  assign rise = sync_reg & ~prev_reg;

endmodule

// File: rtl/pattern_capture.sv
// Recovers a serialized bit pattern from a PWM-style line: hunts for the first
// high bit, samples mid-bit, and closes the burst after a run of low cycles.
module pattern_capture
  import pattern_pkg::*;
#(
  parameter int _PAT_WIDTH = PAT_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_en,
  input  logic                  din,
  input  logic [DUTY_WIDTH-1:0] duty_num,
  input  logic [GAP_WIDTH-1:0]  gap_min,
  output logic [_PAT_WIDTH-1:0] pat_out,
  output logic [7:0]            pat_len,
  output logic                  pat_valid,
  output logic [7:0]            pulse_cnt,
  output logic                  busy,
  output logic                  overflow
);

  logic                  ds;
  logic                  ds_rise;

  logic [1:0]            state_reg;
  sample_ctx_t           ctx_reg;
  sample_ctx_t           ctx_next;
  sample_ctx_t           first_ctx;
  logic [_PAT_WIDTH-1:0] shift_reg;
  logic [_PAT_WIDTH-1:0] shift_next;
  logic [_PAT_WIDTH-1:0] first_shift;
  logic [_PAT_WIDTH-1:0] pat_out_reg;
  logic [7:0]            pat_len_reg;
  logic [7:0]            pulse_cnt_reg;
  logic                  overflow_reg;

  logic [GAP_WIDTH-1:0]  gap_eff;
  logic [GAP_WIDTH-1:0]  low_run_now;
  logic [DUTY_WIDTH-1:0] sample_phase;
  logic                  sample_now;
  logic                  in_range;
  logic                  gap_hit;
  logic                  ovf_hit;
  logic                  first_hit;

  pattern_sync2 u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (din),
    .q    (ds),
    .rise (ds_rise)
  );

  always_comb begin
    gap_eff      = (gap_min == '0) ? GAP_WIDTH'(1) : gap_min;
    sample_phase = duty_num >> 1;
    sample_now   = (ctx_reg.phase == sample_phase);
    in_range     = (ctx_reg.idx < 8'(_PAT_WIDTH));
    low_run_now  = ds ? '0
                 : ((ctx_reg.low_run == '1) ? ctx_reg.low_run : ctx_reg.low_run + 1'b1);
    // The count includes the current cycle, so DONE follows the gap cycle directly.
    gap_hit      = (low_run_now == gap_eff);
    ovf_hit      = sample_now && ds && !in_range;

    ctx_next         = ctx_reg;
    ctx_next.low_run = low_run_now;
    ctx_next.phase   = (ctx_reg.phase >= duty_num) ? '0 : ctx_reg.phase + 1'b1;
    if (sample_now && (ctx_reg.idx != 8'hFF)) ctx_next.idx = ctx_reg.idx + 8'd1;

    // The rise cycle itself is phase 0 of bit 0; with a sample point of 0 it is sampled there.
    first_hit         = (sample_phase == '0);
    first_shift       = '0;
    first_shift[0]    = first_hit;
    first_ctx.idx     = first_hit ? 8'd1 : 8'd0;
    first_ctx.phase   = (duty_num == '0) ? '0 : DUTY_WIDTH'(1);
    first_ctx.low_run = '0;
  end

  for (genvar gi = 0; gi < _PAT_WIDTH; gi++) begin : g_shift
    assign shift_next[gi] = (sample_now && (ctx_reg.idx == 8'(gi))) ? ds : shift_reg[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ctx_reg       <= '0;
      shift_reg     <= '0;
      pat_out_reg   <= '0;
      pat_len_reg   <= '0;
      pulse_cnt_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cap_en) begin
            state_reg     <= ST_HUNT;
            pulse_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
          end
        end
        ST_HUNT: begin
          if (!cap_en) begin
            state_reg <= ST_IDLE;
          end else if (ds_rise) begin
            state_reg <= ST_SAMPLE;
            shift_reg <= first_shift;
            ctx_reg   <= first_ctx;
          end
        end
        ST_SAMPLE: begin
          if (!cap_en) begin
            state_reg <= ST_IDLE;
          end else begin
            shift_reg <= shift_next;
            ctx_reg   <= ctx_next;
            if (ovf_hit) overflow_reg <= 1'b1;
            if (gap_hit) begin
              state_reg   <= ST_DONE;
              pat_out_reg <= shift_next;
              pat_len_reg <= msb_len(64'(shift_next));
              if (pulse_cnt_reg != 8'hFF) pulse_cnt_reg <= pulse_cnt_reg + 8'd1;
            end
          end
        end
        default: begin
          state_reg <= cap_en ? ST_HUNT : ST_IDLE;
        end
      endcase
    end
  end

  assign pat_out   = pat_out_reg;
  assign pat_len   = pat_len_reg;
  assign pat_valid = (state_reg == ST_DONE);
  assign pulse_cnt = pulse_cnt_reg;
  assign busy      = (state_reg == ST_SAMPLE) || (state_reg == ST_DONE);
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_pattern_capture.sv
// Self-checking bench for pattern_capture: directed vector table, hand-written
// corner sequences and randomized bursts against a pattern-level model.
module tb_pattern_capture;

  localparam int W    = 8;
  localparam int LEAD = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         cap_en;
  logic         din;
  logic [7:0]   duty_num;
  logic [15:0]  gap_min;
  logic [W-1:0] pat_out;
  logic [7:0]   pat_len;
  logic         pat_valid;
  logic [7:0]   pulse_cnt;
  logic         busy;
  logic         overflow;

  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  logic model_ovf = 1'b0;

  typedef struct {
    logic [63:0] pat;
    int          nbits;
    int          duty;
    int          gap;
    int          trail;
    logic [63:0] exp_out;
    int          exp_len;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  pattern_capture #(._PAT_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cap_en    (cap_en),
    .din       (din),
    .duty_num  (duty_num),
    .gap_min   (gap_min),
    .pat_out   (pat_out),
    .pat_len   (pat_len),
    .pat_valid (pat_valid),
    .pulse_cnt (pulse_cnt),
    .busy      (busy),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic wave_bit(input logic [63:0] pat, input int nbits, input int bp, input int k);
    if (k < LEAD || k >= LEAD + nbits * bp) return 1'b0;
    return pat[(k - LEAD) / bp];
  endfunction

  task automatic restart_session();
    @(negedge clk);
    din    = 1'b0;
    cap_en = 1'b0;
    repeat (2) @(negedge clk);
    cap_en    = 1'b1;
    model_cnt = 0;
    model_ovf = 1'b0;
    @(negedge clk);
    chk("session_pulse_clear", pulse_cnt, 0);
    chk("session_ovf_clear", overflow, 0);
  endtask

  // One complete burst: serialize, watch pat_valid, compare against expectations.
  task automatic run_burst(input logic [63:0] pat, input int nbits, input int duty, input int gap,
                           input int trail, input logic [63:0] exp_out, input int exp_len,
                           input logic exp_ovf, input string name);
    int bp, gap_eff, tr, total, last_hi, exp_k, nvalid, vk;
    logic [63:0] got_out;
    logic [7:0]  got_len;
    bp      = duty + 1;
    gap_eff = (gap == 0) ? 1 : gap;
    tr      = (trail > gap_eff + 4) ? trail : gap_eff + 4;
    total   = LEAD + nbits * bp + tr;
    last_hi = 0;
    for (int b = 0; b < nbits; b++) if (pat[b]) last_hi = LEAD + b * bp + bp - 1;
    // Two synchronizer stages, gap_eff low cycles, then one cycle to DONE.
    exp_k   = last_hi + gap_eff + 3;
    nvalid  = 0;
    vk      = -1;
    got_out = '0;
    got_len = '0;
    duty_num = 8'(duty);
    gap_min  = 16'(gap);
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (pat_valid) begin
        nvalid++;
        vk      = k;
        got_out = 64'(pat_out);
        got_len = pat_len;
      end
      din = wave_bit(pat, nbits, bp, k);
    end
    model_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
    chk({name, "_valid_count"}, nvalid, 1);
    chk({name, "_latency"}, vk, exp_k);
    chk({name, "_pat_out"}, got_out, exp_out);
    chk({name, "_pat_len"}, got_len, exp_len);
    chk({name, "_pat_out_hold"}, pat_out, exp_out);
    chk({name, "_overflow"}, overflow, exp_ovf);
    chk({name, "_pulse_cnt"}, pulse_cnt, model_cnt);
    $display("burst %s: pat=%0h bits=%0d duty=%0d gap=%0d -> out=%0h len=%0d ovf=%0b cnt=%0d",
             name, pat, nbits, duty, gap, got_out, got_len, overflow, pulse_cnt);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    rst      = 1'b1;
    cap_en   = 1'b0;
    din      = 1'b0;
    duty_num = 8'd3;
    gap_min  = 16'd8;

    tbl[0] = '{64'h0B,  8, 3,  8, 20, 64'h0B, 4, 1'b0};
    tbl[1] = '{64'h3FF, 10, 3, 8, 20, 64'hFF, 8, 1'b1};
    tbl[2] = '{64'h01,  1, 0,  0,  8, 64'h01, 1, 1'b0};
    tbl[3] = '{64'h81,  8, 2, 20, 24, 64'h81, 8, 1'b0};
    tbl[4] = '{64'h7F,  7, 1,  3,  8, 64'h7F, 7, 1'b0};
    tbl[5] = '{64'hFF,  8, 4,  1,  6, 64'hFF, 8, 1'b0};
    tbl[6] = '{64'h2D,  6, 1,  5, 10, 64'h2D, 6, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_pat_out", pat_out, 0);
    chk("reset_pat_len", pat_len, 0);
    chk("reset_pat_valid", pat_valid, 0);
    chk("reset_pulse_cnt", pulse_cnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      restart_session();
      run_burst(tbl[i].pat, tbl[i].nbits, tbl[i].duty, tbl[i].gap, tbl[i].trail,
                tbl[i].exp_out, tbl[i].exp_len, tbl[i].exp_ovf, $sformatf("vec%0d", i));
    end

    // Three back-to-back bursts of the same pattern.
    restart_session();
    for (int i = 0; i < 3; i++) run_burst(64'h05, 8, 3, 8, 16, 64'h05, 3, 1'b0, $sformatf("triple%0d", i));
    chk("triple_pulse_cnt", pulse_cnt, 3);

    // Drop cap_en in the middle of a burst.
    restart_session();
    run_burst(64'h05, 8, 3, 8, 16, 64'h05, 3, 1'b0, "pre_drop");
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pat_valid) nv++;
      if (k == 13) begin
        chk("drop_busy_before", busy, 1);
        cap_en = 1'b0;
      end
      if (k == 14) begin
        chk("drop_busy_after", busy, 0);
        chk("drop_pulse_cnt", pulse_cnt, 1);
      end
      din = wave_bit(64'hFF, 8, 4, k);
    end
    chk("drop_no_valid", nv, 0);
    chk("drop_pulse_cnt_end", pulse_cnt, 1);
    $display("drop: valids=%0d busy=%0b cnt=%0d", nv, busy, pulse_cnt);

    // Asynchronous reset in the middle of SAMPLE.
    restart_session();
    run_burst(64'h0F, 8, 3, 8, 20, 64'h0F, 4, 1'b0, "pre_rst");
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      din = wave_bit(64'hFF, 8, 4, k);
    end
    @(negedge clk);
    chk("rst_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_pat_out", pat_out, 0);
    chk("rst_pat_len", pat_len, 0);
    chk("rst_pat_valid", pat_valid, 0);
    chk("rst_pulse_cnt", pulse_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    $display("reset mid-sample: out=%0h cnt=%0d busy=%0b", pat_out, pulse_cnt, busy);
    din = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    restart_session();
    run_burst(64'h03, 8, 3, 8, 20, 64'h03, 2, 1'b0, "post_rst");

    // Randomized bursts against the pattern-level model.
    for (int i = 0; i < 30; i++) begin
      logic [63:0] pat, eout;
      int nbits, duty, gap, run, mz, elen;
      if (i % 6 == 0) restart_session();
      nbits = $urandom_range(1, 10);
      duty  = $urandom_range(0, 5);
      pat   = (64'($urandom) & ((64'd1 << nbits) - 64'd1)) | 64'd1;
      run = 0;
      mz  = 0;
      for (int b = 0; b < nbits; b++) begin
        if (pat[b]) begin
          if (run > mz) mz = run;
          run = 0;
        end else begin
          run++;
        end
      end
      gap  = mz * (duty + 1) + 1 + int'($urandom_range(0, 3));
      eout = pat & 64'hFF;
      elen = 0;
      for (int b = 0; b < 8; b++) if (eout[b]) elen = b + 1;
      if ((pat >> 8) != 64'd0) model_ovf = 1'b1;
      run_burst(pat, nbits, duty, gap, gap + 6, eout, elen, model_ovf, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
